// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite fetch engine. Walks the attribute list on each line
// start, picks the sprites that cover the line being prepared, fetches one
// 16-pixel tile row per visible column from graphics ROM and hands each row
// to the line buffer as a paced draw command.
module sprite_line_fetch #(
    parameter int OBJ_AW      = 8,
    parameter int DRAW_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [8:0]        line_y,
    input  logic [OBJ_AW:0]   obj_count,
    output logic [OBJ_AW-1:0] obj_addr,
    input  logic [63:0]       obj_data,
    output logic              rom_req,
    output logic [19:0]       rom_addr,
    input  logic              rom_ack,
    input  logic [63:0]       rom_data,
    output logic [63:0]       bits,
    output logic [6:0]        color,
    output logic              prio,
    output logic [9:0]        pos,
    output logic              we,
    output logic              busy
);

    localparam int PW = $clog2(DRAW_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CHECK, S_FETCH, S_EMIT, S_NEXT
    } state_t;

    state_t          state;
    logic [OBJ_AW:0] idx;
    logic [OBJ_AW:0] cnt;
    logic [OBJ_AW:0] idx_nxt;
    logic [8:0]      ly;
    logic [PW-1:0]   pace;
    logic [2:0]      col;

    // Fields of the sprite currently being drawn
    logic [15:0]     s_tile;
    logic [6:0]      s_color;
    logic            s_prio;
    logic            s_flipx;
    logic [9:0]      s_x;
    logic [2:0]      s_last;
    logic [8:0]      s_dyf;
    logic [63:0]     row_bits;

    // Attribute decode for the word presented during CHECK
    logic [8:0]      a_y;
    logic [1:0]      a_h;
    logic [1:0]      a_w;
    logic            a_flipy;
    logic [8:0]      dy;
    logic [8:0]      height;
    logic [8:0]      dyf_chk;
    logic            hit;
    logic [2:0]      c_sel;
    logic [9:0]      pos_next;
    logic            unused_attr;

    assign a_y      = obj_data[8:0];
    assign a_h      = obj_data[10:9];
    assign a_w      = obj_data[12:11];
    assign a_flipy  = obj_data[41];
    assign dy       = ly - a_y;
    assign height   = 9'd16 << a_h;
    assign hit      = (dy < height);
    assign dyf_chk  = a_flipy ? (height - 9'd1 - dy) : dy;
    assign idx_nxt  = idx + 1'b1;
    // Horizontal flip mirrors the column order as well as the pixels
    assign c_sel    = s_flipx ? (s_last - col) : col;
    assign pos_next = s_x + {3'b000, c_sel, 4'b0000};
    assign unused_attr = ^{obj_data[63:58], obj_data[47:42], obj_data[15:13]};

    // Tile row address: columns are 8 tile numbers apart, 16-row blocks step by one
    function automatic logic [19:0] tile_row_addr(input logic [15:0] tile,
                                                  input logic [2:0]  c,
                                                  input logic [8:0]  row);
        logic [15:0] tn;
        tn = tile + {10'b0, c, 3'b000} + {11'b0, row[8:4]};
        return {tn, row[3:0]};
    endfunction

    // Mirror pixel order inside each of the four 16-bit planes
    function automatic logic [63:0] flip_planes(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                r[p*16 + i] = d[p*16 + 15 - i];
        return r;
    endfunction

    // Sprite field latch and ROM row capture (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (state == S_CHECK && hit) begin
            s_tile  <= obj_data[31:16];
            s_color <= obj_data[38:32];
            s_prio  <= obj_data[39];
            s_flipx <= obj_data[40];
            s_x     <= obj_data[57:48];
            s_last  <= (3'd1 << a_w) - 3'd1;
            s_dyf   <= dyf_chk;
        end
        if (state == S_FETCH && rom_ack)
            row_bits <= s_flipx ? flip_planes(rom_data) : rom_data;
    end

    // List walk / fetch / emit controller with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            ly       <= '0;
            pace     <= '0;
            col      <= '0;
            obj_addr <= '0;
            rom_req  <= 1'b0;
            rom_addr <= '0;
            bits     <= '0;
            color    <= '0;
            prio     <= 1'b0;
            pos      <= '0;
            we       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            we <= 1'b0;
            if (pace != '0)
                pace <= pace - 1'b1;
            if (line_start) begin
                // A new line always restarts the walk; pacing keeps running
                state   <= S_READ;
                idx     <= '0;
                cnt     <= obj_count;
                ly      <= line_y;
                busy    <= 1'b1;
                rom_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_READ: begin
                        if (idx == cnt) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            obj_addr <= idx[OBJ_AW-1:0];
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: state <= S_CHECK;
                    S_CHECK: begin
                        if (hit) begin
                            col      <= 3'd0;
                            rom_req  <= 1'b1;
                            rom_addr <= tile_row_addr(obj_data[31:16], 3'd0, dyf_chk);
                            state    <= S_FETCH;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                    S_FETCH: begin
                        if (rom_ack) begin
                            rom_req <= 1'b0;
                            state   <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (pace == '0) begin
                            we    <= 1'b1;
                            bits  <= row_bits;
                            color <= s_color;
                            prio  <= s_prio;
                            pos   <= pos_next;
                            pace  <= PW'(DRAW_CYCLES - 1);
                            if (col != s_last) begin
                                col      <= col + 3'd1;
                                rom_req  <= 1'b1;
                                rom_addr <= tile_row_addr(s_tile, col + 3'd1, s_dyf);
                                state    <= S_FETCH;
                            end else begin
                                state <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        idx <= idx_nxt;
                        if (idx_nxt == cnt) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_READ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch: attribute RAM and ROM models run
// inside the per-cycle tick task; expected ROM addresses and draw commands
// are queued by each step and consumed when the DUT produces them.
module tb_sprite_line_fetch;

    localparam int OBJ_AW      = 8;
    localparam int DRAW_CYCLES = 8;

    logic              clk;
    logic              reset;
    logic              line_start;
    logic [8:0]        line_y;
    logic [OBJ_AW:0]   obj_count;
    logic [OBJ_AW-1:0] obj_addr;
    logic [63:0]       obj_data;
    logic              rom_req;
    logic [19:0]       rom_addr;
    logic              rom_ack;
    logic [63:0]       rom_data;
    logic [63:0]       bits;
    logic [6:0]        color;
    logic              prio;
    logic [9:0]        pos;
    logic              we;
    logic              busy;

    sprite_line_fetch #(.OBJ_AW(OBJ_AW), .DRAW_CYCLES(DRAW_CYCLES)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
        .obj_count(obj_count), .obj_addr(obj_addr), .obj_data(obj_data),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .bits(bits), .color(color), .prio(prio),
        .pos(pos), .we(we), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] bits;
        logic [6:0]  color;
        logic        prio;
        logic [9:0]  pos;
    } draw_t;

    draw_t       draw_q[$];
    logic [19:0] addr_q[$];
    logic [63:0] attr[256];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_we = -1000;
    bit          exact_gap = 0;
    bit          rom_en = 1;
    int          rom_lat = 0;
    int          lat_cnt = 0;
    bit          stale_ack = 0;
    bit          rom_fixed_en = 0;
    logic [63:0] rom_fixed = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rom_fn(input logic [19:0] a);
        return {a[15:0], ~a[15:0], a[19:4] ^ 16'h5A5A, {a[3:0], 12'h801}};
    endfunction

    function automatic logic [63:0] mk_attr(input logic [8:0] y, input logic [1:0] hc,
                                            input logic [1:0] wc, input logic [15:0] tile,
                                            input logic [6:0] col, input logic pr,
                                            input logic fx, input logic fy,
                                            input logic [9:0] x);
        logic [63:0] a;
        a = 64'hA800_2A00_0000_A000;   // junk in the ignored bit ranges
        a[8:0]   = y;
        a[10:9]  = hc;
        a[12:11] = wc;
        a[31:16] = tile;
        a[38:32] = col;
        a[39]    = pr;
        a[40]    = fx;
        a[41]    = fy;
        a[57:48] = x;
        return a;
    endfunction

    task automatic push_draw(input logic [63:0] b, input logic [6:0] c,
                             input logic p, input logic [9:0] x);
        draw_t d;
        d.bits = b; d.color = c; d.prio = p; d.pos = x;
        draw_q.push_back(d);
    endtask

    // One clock: models respond and draws are scored at the falling edge
    task automatic tick();
        draw_t d;
        @(negedge clk);
        cyc++;
        obj_data = attr[obj_addr];
        if (we) begin
            chk("we_expected", (draw_q.size() != 0), 1);
            if (draw_q.size() != 0) begin
                d = draw_q.pop_front();
                chk("draw_bits", bits, d.bits);
                chk("draw_color", color, d.color);
                chk("draw_prio", prio, d.prio);
                chk("draw_pos", pos, d.pos);
            end
            if (last_we >= 0) begin
                if (exact_gap) chk("we_gap_exact", cyc - last_we, DRAW_CYCLES);
                else           chk("we_gap_min", ((cyc - last_we) >= DRAW_CYCLES), 1);
            end
            last_we = cyc;
        end
        if (rom_ack) begin
            rom_ack = 1'b0;
            lat_cnt = 0;
        end else if (stale_ack) begin
            rom_ack   = 1'b1;
            rom_data  = 64'hFFFF_0000_FFFF_0000;
            stale_ack = 0;
        end else if (rom_en && rom_req) begin
            if (lat_cnt >= rom_lat) begin
                chk("rom_req_expected", (addr_q.size() != 0), 1);
                if (addr_q.size() != 0) chk("rom_addr", rom_addr, addr_q.pop_front());
                rom_data = rom_fixed_en ? rom_fixed : rom_fn(rom_addr);
                rom_ack  = 1'b1;
                lat_cnt  = 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    endtask

    task automatic start_line(input logic [8:0] y, input logic [OBJ_AW:0] n);
        line_y     = y;
        obj_count  = n;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
        repeat (3) tick();
        chk({tag, "_draws_left"}, draw_q.size(), 0);
        chk({tag, "_rom_left"}, addr_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {obj_addr, rom_req, rom_addr, we, busy}, 0);
        chk({tag, "_bits"}, bits, 0);
        chk({tag, "_attr"}, {color, prio, pos}, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; line_start = 1'b0; line_y = '0; obj_count = '0;
        rom_ack = 1'b0; rom_data = '0; obj_data = '0;
        for (int i = 0; i < 256; i++) attr[i] = '0;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single sprite
        attr[0] = mk_attr(9'd100, 2'd0, 2'd0, 16'h0123, 7'd5, 1'b0, 1'b0, 1'b0, 10'd50);
        rom_fixed_en = 1; rom_fixed = 64'h8000_0000_0000_0001; rom_lat = 2;
        addr_q.push_back(20'h01233);
        push_draw(64'h8000_0000_0000_0001, 7'd5, 1'b0, 10'd50);
        start_line(9'd103, 9'd1);
        wait_idle("single", 100);
        repeat (4) tick();
        chk("single_bits_hold", bits, 64'h8000_0000_0000_0001);
        chk("single_pos_hold", pos, 10'd50);

        // Both flips
        attr[0] = mk_attr(9'd100, 2'd0, 2'd0, 16'h0123, 7'd5, 1'b0, 1'b1, 1'b1, 10'd50);
        addr_q.push_back(20'h0123C);
        push_draw(64'h0001_0000_0000_8000, 7'd5, 1'b0, 10'd50);
        start_line(9'd103, 9'd1);
        wait_idle("flip", 100);

        // Wide sprite with wrap, zero-latency ack, exact pacing
        rom_fixed_en = 0; rom_lat = 0;
        attr[0] = mk_attr(9'd100, 2'd0, 2'd2, 16'h0123, 7'd9, 1'b1, 1'b0, 1'b0, 10'd1000);
        addr_q.push_back(20'h01233); push_draw(rom_fn(20'h01233), 7'd9, 1'b1, 10'd1000);
        addr_q.push_back(20'h012B3); push_draw(rom_fn(20'h012B3), 7'd9, 1'b1, 10'd1016);
        addr_q.push_back(20'h01333); push_draw(rom_fn(20'h01333), 7'd9, 1'b1, 10'd8);
        addr_q.push_back(20'h013B3); push_draw(rom_fn(20'h013B3), 7'd9, 1'b1, 10'd24);
        last_we = -1000;
        exact_gap = 1;
        start_line(9'd103, 9'd1);
        wait_idle("wide", 200);
        exact_gap = 0;

        // Vertical wrap hit followed by a miss
        rom_lat = 1;
        attr[0] = mk_attr(9'd500, 2'd1, 2'd0, 16'h0400, 7'd7, 1'b1, 1'b0, 1'b0, 10'd200);
        attr[1] = mk_attr(9'd20, 2'd0, 2'd0, 16'h0777, 7'd3, 1'b0, 1'b0, 1'b0, 10'd300);
        addr_q.push_back(20'h04016);
        push_draw(rom_fn(20'h04016), 7'd7, 1'b1, 10'd200);
        start_line(9'd10, 9'd2);
        wait_idle("wrap", 200);

        // Empty list: busy for exactly one cycle
        start_line(9'd10, 9'd0);
        n = 0;
        repeat (5) begin
            if (busy) n++;
            tick();
        end
        chk("empty_busy_cycles", n, 1);

        // Abort during FETCH with ack withheld
        rom_en = 0;
        attr[0] = mk_attr(9'd400, 2'd0, 2'd0, 16'h0555, 7'd1, 1'b0, 1'b0, 1'b0, 10'd10);
        attr[1] = mk_attr(9'd100, 2'd0, 2'd0, 16'h0123, 7'd5, 1'b0, 1'b0, 1'b0, 10'd50);
        start_line(9'd103, 9'd2);
        n = 0;
        while (!rom_req && n < 50) begin
            tick();
            n++;
        end
        chk("abort_fetch_reached", rom_req, 1);
        chk("abort_fetch_obj_addr", obj_addr, 1);
        line_y = 9'd300; obj_count = 9'd2; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("abort_req_dropped", rom_req, 0);
        stale_ack = 1;
        tick();
        chk("abort_obj_addr_zero", obj_addr, 0);
        wait_idle("abort", 100);
        rom_en = 1;

        // Reset while the second column's draw is waiting on pacing
        rom_lat = 0;
        attr[0] = mk_attr(9'd100, 2'd0, 2'd1, 16'h0123, 7'd5, 1'b0, 1'b0, 1'b0, 10'd50);
        addr_q.push_back(20'h01233); push_draw(rom_fn(20'h01233), 7'd5, 1'b0, 10'd50);
        addr_q.push_back(20'h012B3);
        start_line(9'd103, 9'd1);
        n = 0;
        while (draw_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("rst_first_draw_seen", draw_q.size(), 0);
        repeat (3) tick();
        reset = 1'b1;
        last_we = -1000;
        tick();
        check_reset_outputs("midline_reset");
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("midline_no_we", we, 0);
        chk("midline_rom_left", addr_q.size(), 0);

        // Cold start after reset
        rom_fixed_en = 1; rom_lat = 2;
        attr[0] = mk_attr(9'd100, 2'd0, 2'd0, 16'h0123, 7'd5, 1'b0, 1'b0, 1'b0, 10'd50);
        addr_q.push_back(20'h01233);
        push_draw(64'h8000_0000_0000_0001, 7'd5, 1'b0, 10'd50);
        start_line(9'd103, 9'd1);
        wait_idle("cold", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
